mode_counter: RTL

- Parametrised, general-purpose successor to the team's fixed 8-bit up-counter.
- Adds programmable terminal value (modulo limit), up/down direction, programmable step, parallel load, and wrap/saturate mode.
- Produces a registered boundary-event pulse, a sticky event flag, and a combinational next-value lookahead.
- Used wherever datapath blocks need frame/beat/address counters with a runtime-set period.

---
 rtl/mode_counter_if.sv | 31 +++
 rtl/mode_counter.sv | 82 ++++++++
 2 files changed

// File: rtl/mode_counter_if.sv
// Control and status bundle for mode_counter. The master drives the counter
// controls and observes the count/status; the slave is the counter itself.
interface mode_counter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic              enable;
  logic              dir;
  logic              mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              load;
  logic [WIDTH-1:0]  load_value;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic [WIDTH-1:0]  next_count;
  logic              tc;
  logic              wrap_flag;
  logic              at_limit;
  logic              at_zero;

  modport master (
    output enable, dir, mode, step, limit, load, load_value, clr_flags,
    input  count, next_count, tc, wrap_flag, at_limit, at_zero
  );

  modport slave (
    input  enable, dir, mode, step, limit, load, load_value, clr_flags,
    output count, next_count, tc, wrap_flag, at_limit, at_zero
  );
endinterface

// File: rtl/mode_counter.sv
// Programmable modulo counter: up/down, runtime step and limit, parallel load,
// wrap or saturate at the boundary, with event pulse, sticky flag and lookahead.
module mode_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP_W      = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input logic           clk,
  input logic           reset,
  mode_counter_if.slave cnt
);
  // Two spare bits so count + step and count + limit + 1 never overflow.
  localparam int unsigned CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             flag_q, flag_d;

  logic [CW-1:0] cnt_w, lim_w, lim1_w, step_w, s_w, sum_w;

  assign cnt_w  = CW'(count_q);
  assign lim_w  = CW'(cnt.limit);
  assign lim1_w = lim_w + CW'(1);
  assign step_w = CW'(cnt.step);
  // A step larger than the whole range would skip past a full period.
  assign s_w    = (step_w > lim1_w) ? lim1_w : step_w;
  assign sum_w  = cnt_w + s_w;

  // Next count and boundary event, in priority order reset > load > enable.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (reset) begin
      count_d = RstVal;
    end else if (cnt.load) begin
      count_d = (cnt.load_value > cnt.limit) ? cnt.limit : cnt.load_value;
    end else if (cnt.enable && (s_w != '0)) begin
      if (cnt_w > lim_w) begin
        // Limit was lowered below the current count: snap back into range.
        count_d = cnt.mode ? cnt.limit : '0;
        tc_d    = 1'b1;
      end else if (cnt.dir) begin
        if (sum_w <= lim_w) begin
          count_d = WIDTH'(sum_w);
        end else if (cnt.mode) begin
          count_d = cnt.limit;
          tc_d    = (count_q != cnt.limit);
        end else begin
          count_d = WIDTH'(sum_w - lim1_w);
          tc_d    = 1'b1;
        end
      end else begin
        if (cnt_w >= s_w) begin
          count_d = WIDTH'(cnt_w - s_w);
        end else if (cnt.mode) begin
          count_d = '0;
          tc_d    = (count_q != '0);
        end else begin
          count_d = WIDTH'(cnt_w + lim1_w - s_w);
          tc_d    = 1'b1;
        end
      end
    end
    // Set wins over clear when both happen in the same cycle.
    flag_d = reset ? 1'b0 : (tc_d | (flag_q & ~cnt.clr_flags));
  end

  // State register; reset value comes through count_d so reset is synchronous.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    tc_q    <= tc_d;
    flag_q  <= flag_d;
  end

  assign cnt.count      = count_q;
  assign cnt.next_count = count_d;
  assign cnt.tc         = tc_q;
  assign cnt.wrap_flag  = flag_q;
  assign cnt.at_limit   = (count_q == cnt.limit);
  assign cnt.at_zero    = (count_q == '0);
endmodule
